pipe_barrel_sft: RTL
====================

// Module: pipe_barrel_sft
// PURPOSE
//  Parametrised, pipelined shift/rotate unit for the execute stage. Supports SLL, SRL, SRA and ROR
//  on an XLEN-bit operand with a selectable number of register stages. Valid/ready handshake on
//  both sides gives full throughput under back-pressure. Flush discards in-flight work on a
//  branch or interrupt redirect. A tag travels with each operation for writeback.
// PARAMETERS
//  XLEN     32               operand width; power of two, >= 8
//  SHAMT_W  $clog2(XLEN)     shift-amount width (derived; do not override)
//  STAGES   2                pipeline register stages, 1..SHAMT_W
//  TAG_W    5                sideband tag width (e.g. rd index)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous reset, active high
//  flush      in   1        discard all in-flight operations
//  in_valid   in   1        operation offered
//  in_ready   out  1        operation accepted when in_valid & in_ready
//  in_data    in   XLEN     operand
//  in_shamt   in   SHAMT_W  shift/rotate amount (0..XLEN-1)
//  in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_tag     in   TAG_W    sideband, returned unchanged with the result
//  out_valid  out  1        result available
//  out_ready  in   1        result consumed when out_valid & out_ready
//  out_data   out  XLEN     result
//  out_tag    out  TAG_W    tag of the result
// BEHAVIOUR
//  - Reset (rst high at posedge): all stage valids = 0; all stage data/tag/op/shamt regs = 0.
//    out_valid = 0, out_data = 0, out_tag = 0. in_ready = 1 from the first cycle after reset
//    (unless flush is high). Reset mid-operation drops every in-flight item; no result is emitted.
//  - Datapath: log-shifter levels j = 0..SHAMT_W-1 shift by 2^j when shamt[j] = 1.
//    Right ops bit-reverse the operand on entry and the result on exit.
//    Fill bit: 0 for SLL and SRL; operand[XLEN-1] for SRA.
//    ROR uses the same levels with wrap-around fill (bits shifted out re-enter), no fill bit.
//  - Partitioning: level j is computed in stage floor(j*STAGES/SHAMT_W). Each stage ends in a
//    register holding valid, partial data, remaining shamt, op, fill bit and tag.
//    The last stage register drives out_* directly; no combinational path from in_* to out_*.
//  - Latency: an op accepted in cycle c gives out_valid = 1 in cycle c+STAGES, absent stalls.
//  - Flow control: stage k advances when valid[k] = 0, or when stage k+1 advances (last stage:
//    out_ready = 1). in_ready = ~flush & (stage 0 empty or advancing). This gives one op per cycle
//    at full rate. Under stall, all register contents hold and order is preserved.
//    Capacity = STAGES items.
//  - out_data and out_tag are stable while out_valid = 1 and out_ready = 0.
//  - Flush: at the posedge where flush = 1, all stage valids clear. in_ready = 0 during the flush
//    cycle, so a simultaneous in_valid is not accepted. An output handshake in that same cycle
//    still completes: the consumer owns that result. Flush with rst: reset dominates, same effect.
//  - Shamt 0: result = operand for all ops. Shamt is taken modulo XLEN by construction.
//  - Data regs of invalid stages may hold stale values; out_data is don't-care when
//    out_valid = 0, except after reset (0).
// TESTING (XLEN=32, STAGES=2 unless stated)
//  1 SLL 0x0000_0001 by 31 -> 0x8000_0000 at c+2; SLL 0x1234_5678 by 0 -> 0x1234_5678
//  2 SRA 0x8000_0000 by 4 -> 0xF800_0000; SRL 0x8000_0000 by 4 -> 0x0800_0000;
//    SRA 0x7FFF_FFFF by 31 -> 0x0000_0000
//  3 ROR 0x0000_00F1 by 4 -> 0x1000_000F; ROR 0xDEAD_BEEF by 16 -> 0xBEEF_DEAD
//  4 back-to-back ops with out_ready held 0 for 5 cycles:
//    - in_ready drops after 2 accepts
//    - outputs hold stable
//    - on release, results arrive in order with tags 1,2,3..., one per cycle, none lost or duplicated
//  5 flush with 2 ops in flight plus in_valid = 1 that cycle:
//    - no out_valid afterwards for those ops
//    - the next op issued gives out_valid exactly 2 cycles after its accept
//  6 rst asserted mid-stream:
//    - out_valid = 0, out_data = 0, out_tag = 0 next cycle
//    - in_ready = 1 after release
//  Repeat 1-4 for STAGES=1 (latency 1) and STAGES=5 (latency 5).
//  Random check against a reference model for XLEN=64.

Source files
------------

// File: rtl/pipe_barrel_sft.sv
// Pipelined shift/rotate unit: SLL, SRL, SRA and ROR on an XLEN-bit operand, built as a log shifter.
// The shifter levels are spread across STAGES register stages, and a tag rides along with each operation.
module pipe_barrel_sft #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // valid never depends on ready, and the payload is held while valid is high and ready is low.

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  // One level of the left shifter. Rotate re-inserts the bits that leave the top, and fill
  // replicates the fill bit into the vacated low positions.
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] v, input int j,
                                                   input logic rot, input logic fill);
    logic [XLEN-1:0] r;
    int n;
    n = 1 << j;
    r = v << n;
    if (rot) r = r | (v >> (XLEN - n));
    else if (fill) r = r | ~({XLEN{1'b1}} << n);
    return r;
  endfunction

  function automatic int level_stage(input int j);
    return (j * STAGES) / SHAMT_W;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic               src_valid;
    logic [XLEN-1:0]    src_data;
    logic [SHAMT_W-1:0] src_shamt;
    logic [1:0]         src_op;
    logic               src_fill;
    logic [TAG_W-1:0]   src_tag;
    logic [XLEN-1:0]    res;
    logic               adv;
    logic               valid_q;
    logic [XLEN-1:0]    data_q;
    logic [TAG_W-1:0]   tag_q;

    // Right shifts and rotates run through the left shifter on the bit-reversed operand.
    if (k == 0) begin : g_src
      always_comb begin
        src_valid = in_valid & in_ready;
        src_data  = (in_op == OP_SLL) ? in_data : bit_rev(in_data);
        src_shamt = in_shamt;
        src_op    = in_op;
        src_fill  = (in_op == OP_SRA) & in_data[XLEN-1];
        src_tag   = in_tag;
      end
    end else begin : g_src
      always_comb begin
        src_valid = g_stage[k-1].valid_q;
        src_data  = g_stage[k-1].data_q;
        src_shamt = g_stage[k-1].g_side.shamt_q;
        src_op    = g_stage[k-1].g_side.op_q;
        src_fill  = g_stage[k-1].g_side.fill_q;
        src_tag   = g_stage[k-1].tag_q;
      end
    end

    if (k == STAGES - 1) begin : g_adv
      assign adv = ~valid_q | out_ready;
    end else begin : g_adv
      assign adv = ~valid_q | g_stage[k+1].adv;
    end

    always_comb begin
      res = src_data;
      for (int j = 0; j < SHAMT_W; j++)
        if (level_stage(j) == k && src_shamt[j])
          res = shift_level(res, j, src_op == OP_ROR, src_fill);
      if (k == STAGES - 1 && src_op != OP_SLL) res = bit_rev(res);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        if (flush) valid_q <= 1'b0;
        else if (adv) valid_q <= src_valid;
        if (adv && src_valid) begin
          data_q <= res;
          tag_q  <= src_tag;
        end
      end
    end

    // The final stage keeps only what leaves the unit. By then no shift amount remains,
    // and op and fill have been consumed.
    if (k < STAGES - 1) begin : g_side
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         op_q;
      logic               fill_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_q <= '0;
          op_q    <= 2'b00;
          fill_q  <= 1'b0;
        end else if (adv && src_valid) begin
          shamt_q <= src_shamt;
          op_q    <= src_op;
          fill_q  <= src_fill;
        end
      end
    end
  end

  assign in_ready  = ~flush & g_stage[0].adv;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_data  = g_stage[STAGES-1].data_q;
  assign out_tag   = g_stage[STAGES-1].tag_q;

endmodule
